// File: rtl/gpio_cond_pkg.sv
// gpio_cond_pkg
//   Shared definitions for the GPIO input conditioner: legal parameter
//   bounds and the per-bit debounce state decode.
//   Optional feature macro: GPIO_COND_GLITCH_EN (glitch flags in the cells).
package gpio_cond_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int DB_W_MAX        = 24;

    // STABLE : synchronized input equals the held level
    // COUNT  : synchronized input differs, counting toward commit
    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_e;

endpackage

// File: rtl/gpio_db_cell.sv
// gpio_db_cell
//   One bit of input conditioning: synchronizer chain, debounce counter with
//   >= terminal compare, registered change strobe and (optionally) a sticky
//   glitch flag.
//   Optional feature macro: GPIO_COND_GLITCH_EN adds glitch_clr_i/glitch_o.
//
//   Ports
//     clk_i        clock (PCLK)
//     rst_i        asynchronous active-high reset
//     pad_i        raw asynchronous pad level
//     bypass_i     1 = synchronize only, no debounce
//     db_limit_i   stable-count limit
//     level_o      debounced level
//     change_o     one-cycle pulse when level_o changes
//     glitch_clr_i clear for glitch_o          (GPIO_COND_GLITCH_EN only)
//     glitch_o     sticky aborted-count flag   (GPIO_COND_GLITCH_EN only)
//
//   state  | meaning
//   STABLE | s equals q, counter idle
//   COUNT  | s differs from q, counter advancing toward commit
module gpio_db_cell
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pad_i,
    input  logic            bypass_i,
    input  logic [DB_W-1:0] db_limit_i,
    output logic            level_o,
    output logic            change_o
`ifdef GPIO_COND_GLITCH_EN
   ,input  logic            glitch_clr_i,
    output logic            glitch_o
`endif
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   q_q, q_d;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   change_q;
    db_state_e              state;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    assign s      = sync_q[SYNC_STAGES-1];
    assign state  = (s != q_q) ? COUNT : STABLE;

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (bypass_i) begin
            // Bypass discards any count in progress.
            q_d   = s;
            cnt_d = '0;
        end else begin
            case (state)
                STABLE: cnt_d = '0;
                COUNT: begin
                    if (cnt_q >= db_limit_i) begin
                        q_d   = s;
                        cnt_d = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            q_q      <= 1'b0;
            cnt_q    <= '0;
            change_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            change_q <= (q_d != q_q);
        end
    end

    assign level_o  = q_q;
    assign change_o = change_q;

`ifdef GPIO_COND_GLITCH_EN
    logic glitch_q, glitch_d;
    logic abort;

    // Abort: input fell back to the held level while a count was running.
    assign abort    = !bypass_i && (state == STABLE) && (cnt_q != '0);
    // Set has priority over clear.
    assign glitch_d = (glitch_q & ~glitch_clr_i) | abort;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) glitch_q <= 1'b0;
        else       glitch_q <= glitch_d;
    end

    assign glitch_o = glitch_q;
`endif

endmodule

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
//   Synchronizes and debounces IO_NUM raw pad inputs into the PCLK domain
//   and presents clean levels to CoreGPIO GPIO_IN, plus per-bit change pulses.
//   Optional feature macro: GPIO_COND_GLITCH_EN adds GLITCH / GLITCH_CLR.
//
//   Ports
//     PCLK        clock, rising edge
//     PRESET      asynchronous active-high reset
//     PAD_IN      raw pad inputs
//     DB_LIMIT    debounce stable-count (quasi-static)
//     BYPASS      per-bit debounce bypass
//     GPIO_IN     conditioned levels
//     CHANGE      one-cycle pulse per GPIO_IN transition
//     GLITCH      sticky glitch flags          (GPIO_COND_GLITCH_EN only)
//     GLITCH_CLR  per-bit glitch clear         (GPIO_COND_GLITCH_EN only)
module gpio_in_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int IO_NUM      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [IO_NUM-1:0] PAD_IN,
    input  logic [DB_W-1:0]   DB_LIMIT,
    input  logic [IO_NUM-1:0] BYPASS,
    output logic [IO_NUM-1:0] GPIO_IN,
    output logic [IO_NUM-1:0] CHANGE
`ifdef GPIO_COND_GLITCH_EN
   ,output logic [IO_NUM-1:0] GLITCH,
    input  logic [IO_NUM-1:0] GLITCH_CLR
`endif
);

    for (genvar i = 0; i < IO_NUM; i++) begin : g_bit
        gpio_db_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W)
        ) u_cell (
            .clk_i        (PCLK),
            .rst_i        (PRESET),
            .pad_i        (PAD_IN[i]),
            .bypass_i     (BYPASS[i]),
            .db_limit_i   (DB_LIMIT),
            .level_o      (GPIO_IN[i]),
            .change_o     (CHANGE[i])
`ifdef GPIO_COND_GLITCH_EN
           ,.glitch_clr_i (GLITCH_CLR[i]),
            .glitch_o     (GLITCH[i])
`endif
        );
    end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
module tb_gpio_in_conditioner;

    logic        PCLK;
    logic        PRESET;
    logic [31:0] PAD_IN;
    logic [15:0] DB_LIMIT;
    logic [31:0] BYPASS;
    logic [31:0] GPIO_IN;
    logic [31:0] CHANGE;
`ifdef GPIO_COND_GLITCH_EN
    logic [31:0] GLITCH;
    logic [31:0] GLITCH_CLR;
`endif

    int n_vec = 0;
    int n_err = 0;

    gpio_in_conditioner #(
        .IO_NUM      (32),
        .SYNC_STAGES (2),
        .DB_W        (16)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .PAD_IN     (PAD_IN),
        .DB_LIMIT   (DB_LIMIT),
        .BYPASS     (BYPASS),
        .GPIO_IN    (GPIO_IN),
        .CHANGE     (CHANGE)
`ifdef GPIO_COND_GLITCH_EN
       ,.GLITCH     (GLITCH),
        .GLITCH_CLR (GLITCH_CLR)
`endif
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] pad;
        logic [31:0] byp;
        logic [15:0] lim;
        int          edges;
        logic [31:0] exp_gpio;
        logic [31:0] exp_chg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [31:0] pad, input logic [31:0] byp,
                       input logic [15:0] lim, input int edges,
                       input logic [31:0] g, input logic [31:0] c);
        vec_t v;
        v.pad = pad; v.byp = byp; v.lim = lim; v.edges = edges;
        v.exp_gpio = g; v.exp_chg = c;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Clean edge on bit 0, DB_LIMIT=5: commit 2+5+1 = 8 edges after the pad edge
        add(32'h1, 32'h0, 16'd5, 7, 32'h1 & 32'h0, 32'h0);
        add(32'h1, 32'h0, 16'd5, 1, 32'h1, 32'h1);
        add(32'h1, 32'h0, 16'd5, 1, 32'h1, 32'h0);
        // 4-cycle glitch on bit 3: rejected
        add(32'h9, 32'h0, 16'd5, 4, 32'h1, 32'h0);
        add(32'h1, 32'h0, 16'd5, 6, 32'h1, 32'h0);
        // 6-cycle pulse on bit 4 (DB_LIMIT+1): accepted, then released
        add(32'h11, 32'h0, 16'd5, 6, 32'h1, 32'h0);
        add(32'h1, 32'h0, 16'd5, 2, 32'h11, 32'h10);
        add(32'h1, 32'h0, 16'd5, 5, 32'h11, 32'h0);
        add(32'h1, 32'h0, 16'd5, 1, 32'h1, 32'h10);
        // 5-cycle pulse on bit 5 (DB_LIMIT): rejected
        add(32'h21, 32'h0, 16'd5, 5, 32'h1, 32'h0);
        add(32'h1, 32'h0, 16'd5, 10, 32'h1, 32'h0);
        // DB_LIMIT=0 on bit 2: commit 3 edges after pad edge
        add(32'h5, 32'h0, 16'd0, 2, 32'h1, 32'h0);
        add(32'h5, 32'h0, 16'd0, 1, 32'h5, 32'h4);
        add(32'h1, 32'h0, 16'd0, 3, 32'h1, 32'h4);
        add(32'h1, 32'h0, 16'd0, 1, 32'h1, 32'h0);
        // Bypass bit 7, DB_LIMIT=100, 1-cycle pad pulse
        add(32'h81, 32'h80, 16'd100, 1, 32'h1, 32'h0);
        add(32'h1, 32'h80, 16'd100, 1, 32'h1, 32'h0);
        add(32'h1, 32'h80, 16'd100, 1, 32'h81, 32'h80);
        add(32'h1, 32'h80, 16'd100, 1, 32'h1, 32'h80);
        add(32'h1, 32'h80, 16'd100, 1, 32'h1, 32'h0);
        // Bit 1 with DB_LIMIT=20; after 10 counts lower to 4 -> commit next edge
        add(32'h3, 32'h0, 16'd20, 12, 32'h1, 32'h0);
        add(32'h3, 32'h0, 16'd4, 1, 32'h3, 32'h2);
        add(32'h3, 32'h0, 16'd4, 1, 32'h3, 32'h0);

        PRESET   = 1'b1;
        PAD_IN   = '1;
        DB_LIMIT = 16'd3;
        BYPASS   = '0;
`ifdef GPIO_COND_GLITCH_EN
        GLITCH_CLR = '0;
`endif
        repeat (3) tick();
        check("rst_gpio", GPIO_IN, 32'h0);
        check("rst_change", CHANGE, 32'h0);

        // Pad held high through reset reappears 2+3+1 edges after release
        PRESET = 1'b0;
        repeat (5) tick();
        check("rel_gpio_e5", GPIO_IN, 32'h0);
        tick();
        check("rel_gpio_e6", GPIO_IN, 32'hFFFF_FFFF);
        check("rel_change_e6", CHANGE, 32'hFFFF_FFFF);
        tick();
        check("rel_change_e7", CHANGE, 32'h0);

        PAD_IN = '0;
        repeat (5) tick();
        check("fall_gpio_e5", GPIO_IN, 32'hFFFF_FFFF);
        tick();
        check("fall_gpio_e6", GPIO_IN, 32'h0);
        check("fall_change_e6", CHANGE, 32'hFFFF_FFFF);
        tick();
        check("fall_change_e7", CHANGE, 32'h0);

        foreach (tbl[k]) begin
            PAD_IN   = tbl[k].pad;
            BYPASS   = tbl[k].byp;
            DB_LIMIT = tbl[k].lim;
            repeat (tbl[k].edges) tick();
            check($sformatf("vec%0d_gpio", k), GPIO_IN, tbl[k].exp_gpio);
            check($sformatf("vec%0d_change", k), CHANGE, tbl[k].exp_chg);
        end

`ifdef GPIO_COND_GLITCH_EN
        check("glitch_flags", GLITCH, 32'h28);
        GLITCH_CLR = 32'h8;
        tick();
        GLITCH_CLR = '0;
        check("glitch_clr3", GLITCH, 32'h20);
`endif

        // Reset mid-count: bit 1 falling with DB_LIMIT=10, cnt reaches 7
        DB_LIMIT = 16'd10;
        PAD_IN   = 32'h1;
        repeat (9) tick();
        check("midcnt_gpio", GPIO_IN, 32'h3);
        #2;
        PRESET = 1'b1;
        #1;
        check("async_rst_gpio", GPIO_IN, 32'h0);
        check("async_rst_change", CHANGE, 32'h0);
        PAD_IN = '0;
        repeat (2) tick();
        PRESET = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            check("post_rst_change", CHANGE, 32'h0);
        end
        check("post_rst_gpio", GPIO_IN, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
